// File: rtl/ram_key_loader.sv
// ram_key_loader: debounced switch/key front end issuing verified single-cycle RAM writes
module ram_key_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 4,
  parameter int READ_LATENCY    = 2
) (
  input  logic              FPGA_CLK1_50,
  input  logic              reset,
  input  logic [3:0]        SW,
  input  logic [1:0]        KEY,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              mismatch
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(READ_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WRITE, WAIT, CHECK} state_t;
  state_t state_q, state_d;
  logic [1:0] s1_q, s2_q, deb_q, deb_d, press;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic mm_q, mm_d;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (s2_q[i] != deb_q[i] && cnt_q[i] != CW'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + 1'b1 : '0;
      deb_d[i] = (s2_q[i] != deb_q[i] && cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) ? s2_q[i] : deb_q[i];
      press[i] = deb_q[i] & ~deb_d[i];
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    mm_d    = mm_q;
    case (state_q)
      IDLE: begin
        addr_d  = press[1] ? ADDR_W'(SW) : addr_q;
        data_d  = press[0] ? DATA_W'(SW) : data_q;
        state_d = press[0] ? WRITE : IDLE;
      end
      WRITE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d  = wcnt_q + 1'b1;
        state_d = (wcnt_q == LW'(READ_LATENCY - 1)) ? CHECK : WAIT;
      end
      CHECK: begin
        mm_d    = mm_q | (ram_q != data_q);
        addr_d  = addr_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      s1_q    <= '1;
      s2_q    <= '1;
      deb_q   <= '1;
      cnt_q   <= '0;
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
      mm_q    <= 1'b0;
    end else begin
      s1_q    <= KEY;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      mm_q    <= mm_d;
    end
  end
  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign ram_wren    = (state_q == WRITE);
  assign busy        = (state_q != IDLE);
  assign mismatch    = mm_q;
endmodule

// File: tb/tb_ram_key_loader.sv
// tb_ram_key_loader: table-driven and scoreboard checks of ram_key_loader against a behavioural RAM
module tb_ram_key_loader;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] SW = 4'h0;
  logic [1:0] KEY = 2'b11, KEY2 = 2'b11;
  logic [3:0] ram_q, ram_data, ram_data2;
  logic [4:0] ram_address, ram_address2;
  logic ram_wren, busy, mismatch, ram_wren2, busy2, mismatch2;
  logic [3:0] mem [32];
  logic [4:0] ar;
  logic [3:0] qr;
  bit bad;
  int n_vec, n_err, blen, fast_wren;
  logic [8:0] obs_q[$], exp_q[$];
  int len_q[$];
  logic [4:0] fall_q[$];
  typedef struct {
    bit ld; logic [3:0] a; logic [3:0] d; bit bad;
    logic [4:0] ea; logic [4:0] en; bit em;
  } vec_t;
  vec_t v[4];
  always #5 clk = ~clk;
  ram_key_loader #(.DEBOUNCE_CYCLES(D), .ADDR_W(5), .DATA_W(4), .READ_LATENCY(2)) dut (
    .FPGA_CLK1_50(clk), .reset(reset), .SW(SW), .KEY(KEY), .ram_q(ram_q),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .busy(busy), .mismatch(mismatch));
  ram_key_loader #(.DEBOUNCE_CYCLES(1), .ADDR_W(5), .DATA_W(4), .READ_LATENCY(12)) u_fast (
    .FPGA_CLK1_50(clk), .reset(reset), .SW(SW), .KEY(KEY2), .ram_q(4'h0),
    .ram_address(ram_address2), .ram_data(ram_data2), .ram_wren(ram_wren2),
    .busy(busy2), .mismatch(mismatch2));
  // Registered address and registered output: two-cycle read latency
  always @(posedge clk) begin
    ar <= ram_address;
    if (ram_wren) mem[ram_address] <= ram_data;
    qr <= mem[ar];
  end
  assign ram_q = bad ? 4'h0 : qr;
  initial forever begin
    @(negedge clk);
    if (ram_wren) obs_q.push_back({ram_address, ram_data});
    if (reset) blen = 0;
    else if (busy) blen++;
    else if (blen != 0) begin
      len_q.push_back(blen);
      fall_q.push_back(ram_address);
      blen = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (ram_wren2) fast_wren++;
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic press(input int k, input logic [3:0] sw, input bit chatter);
    SW = sw;
    if (chatter) begin
      for (int j = 0; j < 4; j++) begin
        KEY[k] = j[0];
        @(negedge clk);
      end
      chk("chatter_no_event", obs_q.size(), 0);
    end
    KEY[k] = 1'b0;
    repeat (D + 10) @(negedge clk);
    KEY[k] = 1'b1;
    repeat (D + 6) @(negedge clk);
  endtask
  task automatic do_write(input bit ld, input logic [3:0] a, input logic [3:0] d, input bit b,
                          input logic [4:0] ea, input logic [4:0] en, input bit em, input bit chatter);
    logic [8:0] o, e;
    if (ld) press(1, a, 1'b0);
    bad = b;
    exp_q.push_back({ea, d});
    press(0, d, chatter);
    for (int i = 0; i < 50 && len_q.size() == 0; i++) @(negedge clk);
    if (len_q.size() == 0) chk("busy_fall_timeout", 0, 1);
    else begin
      chk("busy_len", len_q.pop_front(), 4);
      chk("next_addr", int'(fall_q.pop_front()), int'(en));
    end
    chk("wren_count", obs_q.size(), 1);
    e = exp_q.pop_front();
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front();
      chk("wr_addr", int'(o[8:4]), int'(e[8:4]));
      chk("wr_data", int'(o[3:0]), int'(e[3:0]));
    end
    obs_q.delete();
    chk("data_hold", int'(ram_data), int'(d));
    chk("mismatch", int'(mismatch), int'(em));
    bad = 1'b0;
  endtask
  initial begin
    v[0] = '{1'b1, 4'hA, 4'h5, 1'b0, 5'h0A, 5'h0B, 1'b0};
    v[1] = '{1'b0, 4'h0, 4'hC, 1'b0, 5'h0B, 5'h0C, 1'b0};
    v[2] = '{1'b1, 4'h3, 4'h7, 1'b1, 5'h03, 5'h04, 1'b1};
    v[3] = '{1'b0, 4'h0, 4'h9, 1'b0, 5'h04, 5'h05, 1'b1};
    repeat (5) @(negedge clk);
    chk("rst_addr", int'(ram_address), 0);
    chk("rst_data", int'(ram_data), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (1000) @(negedge clk);
    chk("idle_no_wren", obs_q.size(), 0);
    chk("idle_wren", int'(ram_wren), 0);
    chk("idle_mismatch", int'(mismatch), 0);
    for (int i = 0; i < 4; i++)
      do_write(v[i].ld, v[i].a, v[i].d, v[i].bad, v[i].ea, v[i].en, v[i].em, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_clears_mismatch", int'(mismatch), 0);
    chk("reset_addr", int'(ram_address), 0);
    do_write(1'b0, 4'h0, 4'h6, 1'b0, 5'h00, 5'h01, 1'b0, 1'b1);
    do_write(1'b1, 4'hF, 4'h0, 1'b0, 5'h0F, 5'h10, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++)
      do_write(1'b0, 4'h0, 4'(i), 1'b0, 5'(15 + i), 5'(16 + i), 1'b0, 1'b0);
    do_write(1'b0, 4'h0, 4'h3, 1'b0, 5'h1F, 5'h00, 1'b0, 1'b0);
    press(1, 4'h6, 1'b0);
    SW = 4'h2;
    KEY[0] = 1'b0;
    for (int i = 0; i < 40 && !ram_wren; i++) @(negedge clk);
    chk("abort_wren_seen", int'(ram_wren), 1);
    @(negedge clk);
    chk("abort_in_wait", int'(busy && !ram_wren), 1);
    reset = 1'b1;
    KEY = 2'b11;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_wren", int'(ram_wren), 0);
    chk("abort_addr", int'(ram_address), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("abort_one_write", obs_q.size(), 1);
    if (obs_q.size() != 0) chk("abort_wr", int'(obs_q.pop_front()), int'({5'h06, 4'h2}));
    repeat (20) @(negedge clk);
    chk("abort_no_extra", obs_q.size(), 0);
    KEY2[0] = 1'b0;
    repeat (5) @(negedge clk);
    KEY2[0] = 1'b1;
    repeat (4) @(negedge clk);
    KEY2[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("fast_busy_at_2nd", int'(busy2), 1);
    KEY2[0] = 1'b1;
    repeat (30) @(negedge clk);
    chk("fast_wren_count", fast_wren, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
endmodule
